// File: rtl/move_scheduler_pkg.sv
// Shared codes for the snake game: FSM states, directions,
// and the speed-to-period mapping used by the move scheduler.
package move_scheduler_pkg;

   typedef enum logic [1:0] {
      GS_RUNNING = 2'b00,
      GS_DIE     = 2'b01,
      GS_INITIAL = 2'b10
   } game_state_t;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_RIGHT = 2'b11
   } dir_t;

   function automatic dir_t opposite(dir_t d);
      return dir_t'({d[1], ~d[0]});
   endfunction

   // max(base - lvl*step, min_p) without unsigned wrap-around
   function automatic logic [31:0] period_for(
      logic [31:0] base,
      logic [31:0] step,
      logic [31:0] min_p,
      logic [2:0]  lvl
   );
      logic [31:0] dec;
      dec = step * {29'd0, lvl};
      if (dec >= base) return min_p;
      if (base - dec < min_p) return min_p;
      return base - dec;
   endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// Button/game-state inputs and move outputs of the move scheduler.
interface move_scheduler_if;
   import move_scheduler_pkg::*;

   logic       up;
   logic       down;
   logic       left;
   logic       right;
   logic [1:0] game_state;
   logic       ate_food;
   logic       move_tick;
   dir_t       dir;
   logic       grow;
   logic [2:0] level;

   modport master (
      output up, down, left, right, game_state, ate_food,
      input  move_tick, dir, grow, level
   );

   modport slave (
      input  up, down, left, right, game_state, ate_food,
      output move_tick, dir, grow, level
   );

endinterface

// File: rtl/move_scheduler_dir_filter.sv
// Button priority decode and pending direction register; rejects
// requests that would reverse or repeat the committed direction.
module dir_filter
   import move_scheduler_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic init,
   input  logic up,
   input  logic down,
   input  logic left,
   input  logic right,
   input  dir_t ref_dir,
   output dir_t pending_dir
);

   dir_t req;
   logic valid;
   logic accept;

   always_comb begin
      req   = DIR_RIGHT;
      valid = 1'b1;
      priority case (1'b1)
         up:      req = DIR_UP;
         down:    req = DIR_DOWN;
         left:    req = DIR_LEFT;
         right:   req = DIR_RIGHT;
         default: valid = 1'b0;
      endcase
   end

   assign accept = en && valid &&
                   (req != ref_dir) &&
                   (req != opposite(ref_dir));

   always_ff @(posedge clk) begin
      if (rst)
         pending_dir <= DIR_RIGHT;
      else if (accept)
         pending_dir <= req;
      else if (init)
         pending_dir <= DIR_RIGHT;
   end

endmodule

// File: rtl/move_scheduler.sv
// Move timing for the snake: period counter, speed level from
// food count, grow flag and committed direction.
module move_scheduler
   import move_scheduler_pkg::*;
#(
   parameter int unsigned BASE_PERIOD     = 25_000_000,
   parameter int unsigned STEP_DEC        = 2_000_000,
   parameter int unsigned MIN_PERIOD      = 5_000_000,
   parameter int unsigned FOODS_PER_LEVEL = 4,
   parameter int unsigned MAX_LEVEL       = 7
)(
   input logic             clk,
   input logic             rst,
   move_scheduler_if.slave bus
);

   localparam logic [31:0] BASE      = 32'(BASE_PERIOD);
   localparam logic [31:0] STEP      = 32'(STEP_DEC);
   localparam logic [31:0] FLOOR     = 32'(MIN_PERIOD);
   localparam logic [7:0]  LAST_FOOD = 8'(FOODS_PER_LEVEL - 1);
   localparam logic [2:0]  MAX_LVL   = 3'(MAX_LEVEL);

   logic        running;
   logic        init;
   logic        tick;
   logic        eat;
   logic [31:0] counter;
   logic [31:0] cur_period;
   dir_t        dir_q;
   dir_t        pending_dir;
   dir_t        ref_dir;
   logic [2:0]  level_q;
   logic [7:0]  food_cnt;
   logic        grow_pending;

   assign running = (bus.game_state == GS_RUNNING);
   assign init    = (bus.game_state == GS_INITIAL);
   assign tick    = running && (counter == cur_period - 32'd1);
   assign eat     = running && bus.ate_food;

   // on a tick the pending value is what becomes committed at this edge
   assign ref_dir = init ? DIR_RIGHT : (tick ? pending_dir : dir_q);

   dir_filter u_dir_filter (
      .clk         (clk),
      .rst         (rst),
      .en          (running | init),
      .init        (init),
      .up          (bus.up),
      .down        (bus.down),
      .left        (bus.left),
      .right       (bus.right),
      .ref_dir     (ref_dir),
      .pending_dir (pending_dir)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         counter      <= '0;
         cur_period   <= BASE;
         dir_q        <= DIR_RIGHT;
         level_q      <= '0;
         food_cnt     <= '0;
         grow_pending <= 1'b0;
      end else begin
         if (counter == '0)
            cur_period <= period_for(BASE, STEP, FLOOR, level_q);
         if (init) begin
            counter      <= '0;
            dir_q        <= DIR_RIGHT;
            level_q      <= '0;
            food_cnt     <= '0;
            grow_pending <= 1'b0;
         end else if (running) begin
            counter <= tick ? '0 : counter + 32'd1;
            if (tick)
               dir_q <= pending_dir;
            if (tick)
               grow_pending <= 1'b0;
            else if (eat)
               grow_pending <= 1'b1;
            if (eat) begin
               if (food_cnt == LAST_FOOD) begin
                  food_cnt <= '0;
                  if (level_q < MAX_LVL)
                     level_q <= level_q + 3'd1;
               end else begin
                  food_cnt <= food_cnt + 8'd1;
               end
            end
         end
      end
   end

   assign bus.move_tick = tick;
   assign bus.dir       = dir_q;
   assign bus.grow      = tick && (grow_pending || bus.ate_food);
   assign bus.level     = level_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with a queue of expected
// move events (period length, grow, committed direction).
module tb_move_scheduler;
   import move_scheduler_pkg::*;

   localparam int LIM = 200;

   typedef struct {
      int         period;
      logic       grow;
      logic [1:0] dir;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   move_scheduler_if bus();

   move_scheduler #(
      .BASE_PERIOD     (20),
      .STEP_DEC        (4),
      .MIN_PERIOD      (8),
      .FOODS_PER_LEVEL (2),
      .MAX_LEVEL       (7)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t       sb[$];
   int         total = 0;
   int         bad = 0;
   int         pos;
   int         mlvl, mfood, mper;
   logic       mgp;
   logic [1:0] mdir, mpend;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int per(int l);
      return (20 - 4 * l > 8) ? 20 - 4 * l : 8;
   endfunction

   function automatic logic [1:0] opp(logic [1:0] d);
      return {d[1], ~d[0]};
   endfunction

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic adv(int k);
      repeat (k) begin
         chk("no_tick", bus.move_tick, 0);
         nxt();
         pos++;
      end
   endtask

   task automatic model_ate();
      mgp = 1'b1;
      if (mfood == 1) begin
         mfood = 0;
         if (mlvl < 7) mlvl++;
      end else begin
         mfood++;
      end
   endtask

   task automatic eat(int k);
      repeat (k) begin
         bus.ate_food = 1'b1;
         model_ate();
         adv(1);
         bus.ate_food = 1'b0;
         adv(1);
      end
   endtask

   task automatic press(logic [3:0] b);
      logic [1:0] r;
      {bus.up, bus.down, bus.left, bus.right} = b;
      r = b[3] ? 2'd0 : b[2] ? 2'd1 : b[1] ? 2'd2 : 2'd3;
      if (b != 4'd0 && r != mdir && r != opp(mdir)) mpend = r;
      adv(1);
      {bus.up, bus.down, bus.left, bus.right} = 4'd0;
   endtask

   task automatic do_tick(bit coinc);
      exp_t e;
      int   n;
      n = pos;
      while (!bus.move_tick && n < LIM) begin
         nxt();
         n++;
      end
      if (coinc) begin
         bus.ate_food = 1'b1;
         model_ate();
         #1;
      end
      e = sb.pop_front();
      chk("period", n, e.period);
      chk("grow", bus.grow, e.grow);
      chk("dir_hold", bus.dir, mdir);
      mgp  = 1'b0;
      mdir = mpend;
      nxt();
      bus.ate_food = 1'b0;
      chk("dir", bus.dir, e.dir);
      chk("tick_clear", bus.move_tick, 0);
      mper = per(mlvl);
      pos  = 1;
   endtask

   task automatic expect_tick(bit coinc);
      sb.push_back('{mper, mgp | coinc, mpend});
      do_tick(coinc);
   endtask

   task automatic model_reset();
      mlvl  = 0;
      mfood = 0;
      mgp   = 1'b0;
      mdir  = 2'd3;
      mpend = 2'd3;
      mper  = 20;
      pos   = 1;
   endtask

   initial begin
      {bus.up, bus.down, bus.left, bus.right} = 4'd0;
      bus.ate_food   = 1'b0;
      bus.game_state = GS_INITIAL;
      rst = 1'b1;
      model_reset();
      nxt();
      nxt();
      chk("rst_tick", bus.move_tick, 0);
      chk("rst_grow", bus.grow, 0);
      chk("rst_dir", bus.dir, 3);
      chk("rst_level", bus.level, 0);
      rst = 1'b0;
      repeat (5) nxt();
      chk("init_dir", bus.dir, 3);
      chk("init_level", bus.level, 0);
      chk("init_tick", bus.move_tick, 0);

      bus.game_state = GS_RUNNING;
      pos = 1;
      expect_tick(0);
      expect_tick(0);

      adv(3);
      press(4'b0010);
      press(4'b1000);
      expect_tick(0);
      adv(2);
      press(4'b0100);
      press(4'b0001);
      expect_tick(0);
      adv(1);
      press(4'b0110);
      expect_tick(0);
      adv(1);
      press(4'b1010);
      expect_tick(0);

      adv(3);
      eat(2);
      chk("level1", bus.level, 1);
      expect_tick(0);
      expect_tick(0);
      eat(5);
      expect_tick(0);
      eat(3);
      expect_tick(0);
      eat(2);
      chk("level6", bus.level, 6);
      expect_tick(0);
      eat(3);
      expect_tick(0);
      eat(1);
      chk("level_sat", bus.level, 7);
      expect_tick(0);

      expect_tick(1);
      expect_tick(0);

      adv(5);
      bus.game_state = GS_DIE;
      bus.up = 1'b1;
      bus.ate_food = 1'b1;
      repeat (50) begin
         chk("die_tick", bus.move_tick, 0);
         nxt();
      end
      bus.up = 1'b0;
      bus.ate_food = 1'b0;
      chk("die_level", bus.level, 7);
      chk("die_dir", bus.dir, 32'(mdir));
      bus.game_state = GS_RUNNING;
      expect_tick(0);

      bus.game_state = GS_INITIAL;
      nxt();
      model_reset();
      chk("init2_dir", bus.dir, 3);
      chk("init2_level", bus.level, 0);
      bus.up = 1'b1;
      nxt();
      mpend = 2'd0;
      bus.game_state = GS_RUNNING;
      pos = 1;
      adv(1);
      bus.up = 1'b0;
      expect_tick(0);

      adv(9);
      bus.game_state = GS_DIE;
      repeat (50) begin
         chk("die2_tick", bus.move_tick, 0);
         nxt();
      end
      chk("die2_dir", bus.dir, 0);
      bus.game_state = GS_INITIAL;
      nxt();
      nxt();
      chk("init3_dir", bus.dir, 3);
      model_reset();
      bus.game_state = GS_RUNNING;
      expect_tick(0);

      eat(2);
      press(4'b1000);
      begin
         int n;
         n = pos;
         while (!bus.move_tick && n < LIM) begin
            nxt();
            n++;
         end
      end
      chk("pre_rst_tick", bus.move_tick, 1);
      chk("pre_rst_grow", bus.grow, 1);
      rst = 1'b1;
      nxt();
      chk("post_rst_tick", bus.move_tick, 0);
      chk("post_rst_grow", bus.grow, 0);
      chk("post_rst_dir", bus.dir, 3);
      chk("post_rst_level", bus.level, 0);
      rst = 1'b0;
      model_reset();
      expect_tick(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
